cover_report_sched: RTL and testbench

COVER_REPORT_SCHED -- requirements
Module: cover_report_sched

---
 rtl/cover_report_pkg.sv | 20 ++
 rtl/cover_rr_pick.sv | 40 ++++
 rtl/cover_report_sched.sv | 113 +++++++++++
 tb/tb_cover_report_sched.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cover_report_pkg.sv
// Shared types and parameter defaults for the coverage report scheduler.
package cover_report_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int unsigned DEF_NUM_PORTS  = 4;
  localparam int unsigned DEF_PORT_W     = 2;
  localparam int unsigned DEF_COVER_BASE = 0;
  localparam int unsigned DEF_IDX_W      = 16;

  // Pointer width that still works for a single-point configuration.
  function automatic int unsigned ptr_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cover_rr_pick.sv
// Round-robin picker: lowest request strictly above the last grant, else wrap to lowest.
module cover_rr_pick
  import cover_report_pkg::*;
#(
  parameter int unsigned N     = 8,
  parameter int unsigned PTR_W = ptr_width(N)
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] last,
  output logic [PTR_W-1:0] grant,
  output logic             grant_any
);

  logic [PTR_W-1:0] hi_idx;
  logic [PTR_W-1:0] lo_idx;
  logic             hi_found;
  logic             lo_found;

  // Descending scan so the lowest matching index is the last one written.
  always_comb begin
    hi_idx   = '0;
    lo_idx   = '0;
    hi_found = 1'b0;
    lo_found = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        lo_idx   = PTR_W'(i);
        lo_found = 1'b1;
        if (PTR_W'(i) > last) begin
          hi_idx   = PTR_W'(i);
          hi_found = 1'b1;
        end
      end
    end
  end

  assign grant     = hi_found ? hi_idx : lo_idx;
  assign grant_any = lo_found;

endmodule

// File: rtl/cover_report_sched.sv
// Captures first hit of each cover point and streams one report per point through a registered output.
module cover_report_sched
  import cover_report_pkg::*;
#(
  parameter int unsigned NUM_PORTS  = DEF_NUM_PORTS,
  parameter int unsigned PORT_W     = DEF_PORT_W,
  parameter int unsigned COVER_BASE = DEF_COVER_BASE,
  parameter int unsigned IDX_W      = DEF_IDX_W
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        enable,
  input  logic                        clear,
  input  logic [NUM_PORTS*PORT_W-1:0] valid,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [IDX_W-1:0]            out_index,
  output logic [IDX_W-1:0]            hit_count,
  output logic                        done
);

  localparam int unsigned N     = NUM_PORTS * PORT_W;
  localparam int unsigned PTR_W = ptr_width(N);
  localparam logic [PTR_W-1:0] PTR_INIT = PTR_W'(N - 1);

  state_t           state;
  state_t           state_nxt;
  logic             done_nxt;
  logic [N-1:0]     seen;
  logic [N-1:0]     pending;
  logic [N-1:0]     cap;
  logic [N-1:0]     grant_mask;
  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] grant;
  logic             grant_any;
  logic             hs;
  logic             load;
  logic             drain_done;

  cover_rr_pick #(
    .N     (N),
    .PTR_W (PTR_W)
  ) u_pick (
    .req       (pending),
    .last      (ptr),
    .grant     (grant),
    .grant_any (grant_any)
  );

  assign hs         = out_valid & out_ready;
  assign load       = grant_any & (~out_valid | out_ready);
  assign cap        = (state == RUN) ? (valid & ~seen) : '0;
  assign grant_mask = load ? (N'(1) << grant) : '0;
  assign drain_done = (pending == '0) & (~out_valid | out_ready);

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= done_nxt;
    end
  end

  // Next-state logic; enable during DRAIN is ignored until IDLE is reached
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (enable) state_nxt = RUN;
      RUN:     if (!enable) state_nxt = DRAIN;
      DRAIN:   if (clear || drain_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic: done pulses on the DRAIN to IDLE edge
  always_comb begin
    done_nxt = 1'b0;
    if (state == DRAIN && state_nxt == IDLE) done_nxt = 1'b1;
  end

  // Capture, scheduling and output stage; clear overrides same-cycle hits and handshakes
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      seen      <= '0;
      pending   <= '0;
      ptr       <= PTR_INIT;
      out_valid <= 1'b0;
      out_index <= '0;
      hit_count <= '0;
    end else if (clear) begin
      seen      <= '0;
      pending   <= '0;
      ptr       <= PTR_INIT;
      out_valid <= 1'b0;
      hit_count <= '0;
    end else begin
      seen    <= seen | cap;
      pending <= (pending | cap) & ~grant_mask;
      if (load) begin
        ptr       <= grant;
        out_valid <= 1'b1;
        out_index <= IDX_W'(COVER_BASE) + IDX_W'(grant);
      end else if (hs) begin
        out_valid <= 1'b0;
      end
      if (hs && hit_count != '1) hit_count <= hit_count + IDX_W'(1);
    end
  end

endmodule

// File: tb/tb_cover_report_sched.sv
// Directed bench for cover_report_sched with 8 points based at index 100.
module tb_cover_report_sched;

  localparam int unsigned NP    = 4;
  localparam int unsigned PW    = 2;
  localparam int unsigned N     = NP * PW;
  localparam int unsigned BASE  = 100;
  localparam int unsigned IW    = 16;

  logic          clock;
  logic          reset;
  logic          enable;
  logic          clear;
  logic [N-1:0]  valid;
  logic          out_valid;
  logic          out_ready;
  logic [IW-1:0] out_index;
  logic [IW-1:0] hit_count;
  logic          done;

  int errors;
  int checks;

  cover_report_sched #(
    .NUM_PORTS  (NP),
    .PORT_W     (PW),
    .COVER_BASE (BASE),
    .IDX_W      (IW)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .enable    (enable),
    .clear     (clear),
    .valid     (valid),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_index (out_index),
    .hit_count (hit_count),
    .done      (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    errors    = 0;
    checks    = 0;
    reset     = 1'b1;
    enable    = 1'b0;
    clear     = 1'b0;
    valid     = '0;
    out_ready = 1'b0;
    tick();
    tick();
    #2 reset = 1'b0;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_index", 32'(out_index), 32'd0);
    check("rst_hit_count", 32'(hit_count), 32'd0);
    check("rst_done",      32'(done),      32'd0);
    tick();

    // Single hit on point 2 reported two edges after capture
    enable = 1'b1;
    tick();
    valid     = 8'h04;
    out_ready = 1'b1;
    tick();
    valid = '0;
    check("single_lat_e0", 32'(out_valid), 32'd0);
    tick();
    check("single_valid", 32'(out_valid), 32'd1);
    check("single_index", 32'(out_index), 32'd102);
    tick();
    check("single_one_cycle", 32'(out_valid), 32'd0);
    check("single_count",     32'(hit_count), 32'd1);

    // Repeat hit on an already seen point is ignored
    valid = 8'h04;
    tick();
    valid = '0;
    tick();
    check("repeat_no_report", 32'(out_valid), 32'd0);
    tick();
    check("repeat_no_report2", 32'(out_valid), 32'd0);
    check("repeat_count",      32'(hit_count), 32'd1);

    // All eight points after a clear, streamed in order
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clear_count", 32'(hit_count), 32'd0);
    valid = 8'hFF;
    tick();
    valid = '0;
    for (int k = 0; k < 8; k++) begin
      tick();
      check("burst_valid", 32'(out_valid), 32'd1);
      check("burst_index", 32'(out_index), 32'(BASE + k));
      check("burst_count", 32'(hit_count), 32'(k));
    end
    tick();
    check("burst_end_valid", 32'(out_valid), 32'd0);
    check("burst_end_count", 32'(hit_count), 32'd8);

    // Backpressure holds the report stable
    clear = 1'b1;
    tick();
    clear     = 1'b0;
    out_ready = 1'b0;
    valid     = 8'h03;
    tick();
    valid = '0;
    tick();
    check("bp_valid", 32'(out_valid), 32'd1);
    check("bp_index", 32'(out_index), 32'd100);
    for (int k = 0; k < 5; k++) begin
      tick();
      check("bp_hold_valid", 32'(out_valid), 32'd1);
      check("bp_hold_index", 32'(out_index), 32'd100);
    end
    out_ready = 1'b1;
    tick();
    check("bp_next_index", 32'(out_index), 32'd101);
    check("bp_next_count", 32'(hit_count), 32'd1);
    tick();
    check("bp_end_valid", 32'(out_valid), 32'd0);
    check("bp_end_count", 32'(hit_count), 32'd2);

    // Drain three pending points; hits during drain ignored
    clear = 1'b1;
    tick();
    clear     = 1'b0;
    out_ready = 1'b0;
    valid     = 8'h68;
    tick();
    valid  = '0;
    enable = 1'b0;
    tick();
    check("drain_first_index", 32'(out_index), 32'd103);
    check("drain_first_valid", 32'(out_valid), 32'd1);
    valid = 8'h01;
    tick();
    valid = '0;
    check("drain_hold_index", 32'(out_index), 32'd103);
    check("drain_hold_done",  32'(done),      32'd0);
    out_ready = 1'b1;
    tick();
    check("drain_second_index", 32'(out_index), 32'd105);
    tick();
    check("drain_third_index", 32'(out_index), 32'd106);
    check("drain_third_done",  32'(done),      32'd0);
    tick();
    check("drain_done_pulse", 32'(done),      32'd1);
    check("drain_end_valid",  32'(out_valid), 32'd0);
    check("drain_end_count",  32'(hit_count), 32'd3);
    tick();
    check("drain_done_once",    32'(done),      32'd0);
    check("drain_ignored_hit",  32'(out_valid), 32'd0);

    // Empty drain completes on the next edge
    enable = 1'b1;
    tick();
    enable = 1'b0;
    tick();
    check("empty_drain_enter", 32'(done), 32'd0);
    tick();
    check("empty_drain_done", 32'(done), 32'd1);
    tick();
    check("empty_drain_once", 32'(done), 32'd0);

    // Clear with reports outstanding, beating a same-cycle hit
    enable = 1'b1;
    tick();
    out_ready = 1'b0;
    valid     = 8'h1F;
    tick();
    valid = '0;
    tick();
    check("clr_pre_valid", 32'(out_valid), 32'd1);
    clear = 1'b1;
    valid = 8'h80;
    tick();
    clear = 1'b0;
    valid = '0;
    check("clr_out_valid", 32'(out_valid), 32'd0);
    check("clr_hit_count", 32'(hit_count), 32'd0);
    tick();
    check("clr_no_leftover", 32'(out_valid), 32'd0);
    out_ready = 1'b1;
    valid     = 8'h01;
    tick();
    valid = '0;
    tick();
    check("clr_rehit_valid", 32'(out_valid), 32'd1);
    check("clr_rehit_index", 32'(out_index), 32'd100);
    tick();
    check("clr_rehit_count", 32'(hit_count), 32'd1);

    // Asynchronous reset with reports outstanding
    out_ready = 1'b0;
    valid     = 8'h3E;
    tick();
    valid = '0;
    tick();
    check("arst_pre_index", 32'(out_index), 32'd101);
    #2 reset = 1'b1;
    #1;
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_out_index", 32'(out_index), 32'd0);
    check("arst_hit_count", 32'(hit_count), 32'd0);
    #1 reset = 1'b0;
    out_ready = 1'b1;
    tick();
    tick();
    tick();
    check("arst_no_stale", 32'(out_valid), 32'd0);
    valid = 8'h20;
    tick();
    valid = '0;
    tick();
    check("arst_rehit_valid", 32'(out_valid), 32'd1);
    check("arst_rehit_index", 32'(out_index), 32'd105);
    tick();
    check("arst_rehit_count", 32'(hit_count), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
